wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 7 +
 rtl/wb_scoreboard.sv | 30 +++
 rtl/wb_arbiter.sv | 69 ++++++
 tb/tb_wb_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: requester indices and register/data widths shared by the writeback arbiter files
package wb_arbiter_pkg;
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int AW = 5;
  localparam int DW = 64;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: 32-entry pending-write scoreboard with busy queries; ports clk/reset_n, set (issue), clr (handshake), we3/r3 bypass, q_rs1/q_rs2 -> busy_rs1/busy_rs2
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic          we3,
  input  logic [AW-1:0] r3,
  input  logic [AW-1:0] q_rs1,
  input  logic [AW-1:0] q_rs2,
  output logic          busy_rs1,
  output logic          busy_rs2
);
  logic [31:0] pending, set_m, clr_m;
  always_comb begin
    set_m = set_en ? 32'd1 << set_rd : '0;
    clr_m = clr_en ? 32'd1 << clr_rd : '0;
  end
  // set applied after clear so a newer producer stays outstanding; bit 0 forced low
  always_ff @(posedge clk)
    if (!reset_n) pending <= '0;
    else pending <= ((pending & ~clr_m) | set_m) & ~32'd1;
  // the write cycle itself still reports busy since pending clears at the handshake
  assign busy_rs1 = pending[q_rs1] || (we3 && r3 == q_rs1 && q_rs1 != '0);
  assign busy_rs2 = pending[q_rs2] || (we3 && r3 == q_rs2 && q_rs2 != '0);
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: ALU/LSU writeback arbiter with registered regfile write port (we3/r3/dw3) and scoreboard busy queries; WB_RR_FAIR_EN selects round-robin, else LSU fixed priority
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rd,
  input  logic [DW-1:0] lsu_data,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] q_rs1,
  input  logic [AW-1:0] q_rs2,
  output logic          busy_rs1,
  output logic          busy_rs2,
  output logic          we3,
  output logic [AW-1:0] r3,
  output logic [DW-1:0] dw3
);
  logic gnt_lsu, xfer;
  logic [AW-1:0] rd;
  logic [DW-1:0] data;
`ifdef WB_RR_FAIR_EN
  logic ptr;
  // ptr names the favoured requester; only a contended grant moves it
  always_ff @(posedge clk)
    if (!reset_n) ptr <= 1'(REQ_ALU);
    else if (alu_valid && lsu_valid) ptr <= gnt_lsu ? 1'(REQ_ALU) : 1'(REQ_LSU);
  assign gnt_lsu = lsu_valid && (!alu_valid || ptr == 1'(REQ_LSU));
`else
  assign gnt_lsu = lsu_valid;
`endif
  assign lsu_ready = reset_n && gnt_lsu;
  assign alu_ready = reset_n && alu_valid && !gnt_lsu;
  assign xfer = alu_ready || lsu_ready;
  assign rd = gnt_lsu ? lsu_rd : alu_rd;
  assign data = gnt_lsu ? lsu_data : alu_data;
  always_ff @(posedge clk)
    if (!reset_n) begin
      we3 <= 1'b0;
      r3 <= '0;
      dw3 <= '0;
    end else begin
      we3 <= xfer && rd != '0;
      if (xfer) begin
        r3 <= rd;
        dw3 <= data;
      end
    end
  wb_scoreboard u_sb (
    .clk(clk),
    .reset_n(reset_n),
    .set_en(issue_valid),
    .set_rd(issue_rd),
    .clr_en(xfer),
    .clr_rd(rd),
    .we3(we3),
    .r3(r3),
    .q_rs1(q_rs1),
    .q_rs2(q_rs2),
    .busy_rs1(busy_rs1),
    .busy_rs2(busy_rs2)
  );
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed bench with a behavioural writeback/scoreboard model checked every cycle
module tb_wb_arbiter;
  logic clk = 0, reset_n, alu_valid, lsu_valid, issue_valid;
  logic alu_ready, lsu_ready, busy_rs1, busy_rs2, we3;
  logic [4:0] alu_rd, lsu_rd, issue_rd, q_rs1, q_rs2, r3;
  logic [63:0] alu_data, lsu_data, dw3;
  int vectors = 0, errs = 0;
  bit run = 0;
  bit [31:0] m_pend;
  bit m_we;
  bit [4:0] m_r3;
  bit [63:0] m_dw3;
`ifdef WB_RR_FAIR_EN
  bit m_fav;
`endif
  always #5 clk = ~clk;
  wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .we3(we3), .r3(r3), .dw3(dw3)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask
  // 0 = no grant, 1 = ALU, 2 = LSU
  function automatic int grant();
    if (!reset_n) return 0;
    if (alu_valid && lsu_valid) begin
`ifdef WB_RR_FAIR_EN
      return m_fav ? 2 : 1;
`else
      return 2;
`endif
    end
    return alu_valid ? 1 : lsu_valid ? 2 : 0;
  endfunction
  function automatic bit busy(input bit [4:0] q);
    return m_pend[q] || (m_we && m_r3 == q && q != 0);
  endfunction
  always @(posedge clk) begin
    int g;
    bit [4:0] rd;
    g = grant();
    if (!reset_n) begin
      m_pend = '0; m_we = 0; m_r3 = 0; m_dw3 = 0;
`ifdef WB_RR_FAIR_EN
      m_fav = 0;
`endif
    end else begin
      m_we = 0;
      if (g != 0) begin
        rd = g == 2 ? lsu_rd : alu_rd;
        m_r3 = rd;
        m_dw3 = g == 2 ? lsu_data : alu_data;
        m_we = rd != 0;
        m_pend[rd] = 0;
`ifdef WB_RR_FAIR_EN
        if (alu_valid && lsu_valid) m_fav = g == 1;
`endif
      end
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
    end
  end
  always @(negedge clk) if (run) begin
    int g;
    g = grant();
    chk("m_alu_ready", alu_ready, g == 1);
    chk("m_lsu_ready", lsu_ready, g == 2);
    chk("m_we3", we3, m_we);
    chk("m_r3", r3, m_r3);
    chk("m_dw3", dw3, m_dw3);
    chk("m_busy_rs1", busy_rs1, busy(q_rs1));
    chk("m_busy_rs2", busy_rs2, busy(q_rs2));
  end
  task automatic go;
    @(posedge clk);
    #1;
  endtask
  initial begin
    alu_rd = 0; alu_data = 0; lsu_rd = 0; lsu_data = 0; issue_valid = 0; issue_rd = 0;
    q_rs1 = 0; q_rs2 = 0;
    reset_n = 0; alu_valid = 1; lsu_valid = 1;
    go; go; #1;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_we3", we3, 0);
    chk("rst_r3", r3, 0);
    chk("rst_dw3", dw3, 0);
    run = 1;
    go;
    reset_n = 1; alu_valid = 1; alu_rd = 5; alu_data = 64'hA5; lsu_valid = 0; #1;
    chk("alu_alone_ready", alu_ready, 1);
    chk("alu_alone_lsu_ready", lsu_ready, 0);
    go; alu_valid = 0; #1;
    chk("alu_wb_we3", we3, 1);
    chk("alu_wb_r3", r3, 5);
    chk("alu_wb_dw3", dw3, 64'hA5);
    go; #1;
    chk("idle_we3", we3, 0);
    chk("idle_r3_hold", r3, 5);
    go;
    alu_valid = 1; alu_rd = 1; alu_data = 64'h11; lsu_valid = 1; lsu_rd = 2; lsu_data = 64'h22;
    for (int i = 0; i < 4; i++) begin
      logic e;
`ifdef WB_RR_FAIR_EN
      e = i[0];
`else
      e = 1;
`endif
      #1;
      chk("contend_lsu_ready", lsu_ready, e);
      chk("contend_alu_ready", alu_ready, !e);
      go;
    end
    alu_valid = 0; lsu_valid = 0; issue_valid = 1; issue_rd = 7;
    go;
    issue_valid = 0; q_rs1 = 7; lsu_valid = 1; lsu_rd = 7; lsu_data = 64'h77; #1;
    chk("pend7_busy", busy_rs1, 1);
    chk("pend7_lsu_ready", lsu_ready, 1);
    go; lsu_valid = 0; #1;
    chk("wb7_we3", we3, 1);
    chk("wb7_r3", r3, 7);
    chk("wb7_busy_bypass", busy_rs1, 1);
    go; #1;
    chk("after7_busy", busy_rs1, 0);
    issue_valid = 1; issue_rd = 9; alu_valid = 1; alu_rd = 9; alu_data = 64'h99;
    go;
    issue_valid = 0; alu_valid = 0; q_rs2 = 9; #1;
    chk("setwin_busy", busy_rs2, 1);
    chk("setwin_we3", we3, 1);
    go; #1;
    chk("setwin_busy_after", busy_rs2, 1);
    alu_valid = 1; alu_rd = 0; alu_data = 64'hFF; q_rs1 = 0; #1;
    chk("rd0_ready", alu_ready, 1);
    go; alu_valid = 0; #1;
    chk("rd0_we3", we3, 0);
    chk("rd0_busy", busy_rs1, 0);
    issue_valid = 1; issue_rd = 3;
    go;
    issue_valid = 0; q_rs1 = 3; #1;
    chk("pend3_busy", busy_rs1, 1);
    go;
    reset_n = 0; alu_valid = 1; lsu_valid = 1; alu_rd = 4; lsu_rd = 6; #1;
    chk("midrst_alu_ready", alu_ready, 0);
    chk("midrst_lsu_ready", lsu_ready, 0);
    go;
    reset_n = 1; alu_valid = 0; lsu_valid = 0; #1;
    chk("midrst_we3", we3, 0);
    chk("midrst_busy3", busy_rs1, 0);
    for (int i = 0; i < 40; i++) begin
      go;
      alu_valid = ((i * 7) % 5) < 3;
      lsu_valid = ((i * 3) % 4) != 0;
      alu_rd = 5'(i);
      lsu_rd = 5'(i * 3 + 1);
      alu_data = 64'(i * 1000);
      lsu_data = ~64'(i);
      issue_valid = (i % 3) == 0;
      issue_rd = 5'(i * 5 + 2);
      q_rs1 = 5'(i + 1);
      q_rs2 = 5'(i * 5 + 29);
    end
    go;
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    go; go;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
